vga_wave_plot: RTL and testbench



---
 rtl/vga_wave_plot_pkg.sv | 24 ++
 rtl/vga_wave_plot_if.sv | 28 ++
 rtl/vga_wave_plot_ram.sv | 29 ++
 rtl/vga_wave_plot.sv | 165 ++++++++++++++++
 tb/tb_vga_wave_plot.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_wave_plot_pkg.sv
// vga_wave_pkg: definitions shared by the waveform plotter.
//   swap_state_e   - bank-swap state machine encodings (IDLE / PENDING)
//   DEF_*_COLOR    - default trace / background / grid colors
//   clamp_row()    - clamps a row value into 0 .. height-1
package vga_wave_pkg;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

  localparam logic [7:0] DEF_FG_COLOR   = 8'hFF;
  localparam logic [7:0] DEF_BG_COLOR   = 8'h00;
  localparam logic [7:0] DEF_GRID_COLOR = 8'h49;

  function automatic logic [31:0] clamp_row(input logic [31:0] row,
                                            input int unsigned height);
    if (row > 32'(height - 1))
      return 32'(height - 1);
    else
      return row;
  endfunction

endpackage

// File: rtl/vga_wave_plot_if.sv
// vga_wave_plot_if: producer-side bus of the waveform plotter.
//   wr_en / wr_addr / wr_data : column write into the back bank
//   swap_req                  : single-cycle bank swap request
//   swap_pending / swap_ack   : swap status (request latched / applied pulse)
//   disp_bank                 : bank currently shown on screen
// master = producer, slave = vga_wave_plot.
interface vga_wave_plot_if #(
  parameter int X_BITS = 11,
  parameter int Y_BITS = 10
);
  logic              wr_en;
  logic [X_BITS-1:0] wr_addr;
  logic [Y_BITS-1:0] wr_data;
  logic              swap_req;
  logic              swap_pending;
  logic              swap_ack;
  logic              disp_bank;

  modport master (
    output wr_en, wr_addr, wr_data, swap_req,
    input  swap_pending, swap_ack, disp_bank
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, swap_req,
    output swap_pending, swap_ack, disp_bank
  );
endinterface

// File: rtl/vga_wave_plot_ram.sv
// wave_line_ram: two banks of WIDTH x Y_BITS row values.
//   clk                         : clock
//   wr_en/wr_bank/wr_addr/wr_data : write port (bank selected per write)
//   rd_bank/rd_addr/rd_data     : registered read port, 1-cycle latency
// Contents are not reset so the array maps onto block RAM.
module wave_line_ram #(
  parameter int WIDTH  = 1280,
  parameter int X_BITS = 11,
  parameter int Y_BITS = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [X_BITS-1:0] wr_addr,
  input  logic [Y_BITS-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [X_BITS-1:0] rd_addr,
  output logic [Y_BITS-1:0] rd_data
);

  logic [Y_BITS-1:0] mem [2][WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_bank][wr_addr] <= wr_data;
    rd_data <= mem[rd_bank][rd_addr];
  end

endmodule

// File: rtl/vga_wave_plot.sv
// vga_wave_plot: single-trace oscilloscope pixel source.
// Takes the VGA stage's count_h/count_v and returns color_out two cycles
// later. One row value per column lives in a double-buffered column RAM;
// the producer fills the back bank and requests a swap, which is applied
// at the first vblank cycle (count_h == 0, count_v == HEIGHT).
// Ports:
//   clk, reset         : pixel clock, synchronous active-high reset
//   count_h, count_v   : counters from the VGA interface stage
//   bus (slave)        : write port, swap request/status, disp_bank
//   color_out          : pixel color, BPP bits
// Optional feature: define VGA_WAVE_PLOT_GRID_EN to draw a GRID_COLOR grid
// every GRID_STEP pixels (power of two) underneath the trace.
module vga_wave_plot
  import vga_wave_pkg::*;
#(
  parameter int             WIDTH      = 1280,
  parameter int             HEIGHT     = 720,
  parameter int             BPP        = 8,
  parameter logic [BPP-1:0] FG_COLOR   = BPP'(DEF_FG_COLOR),
  parameter logic [BPP-1:0] BG_COLOR   = BPP'(DEF_BG_COLOR),
  parameter logic [BPP-1:0] GRID_COLOR = BPP'(DEF_GRID_COLOR),
  parameter int             GRID_STEP  = 64,
  parameter int             X_BITS     = $clog2(WIDTH),
  parameter int             Y_BITS     = $clog2(HEIGHT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          count_h,
  input  logic [31:0]          count_v,
  vga_wave_plot_if.slave       bus,
  output logic [BPP-1:0]       color_out
);

  // ---------------- swap state machine ----------------
  swap_state_e state, state_nx;
  logic        apply;
  logic        vblank_start;
  logic        disp_bank_q;
  logic        swap_ack_q;

  assign vblank_start = (count_h == 32'd0) && (count_v == 32'(HEIGHT));

  always_comb begin
    state_nx = state;
    apply    = 1'b0;
    case (state)
      SWAP_IDLE:    if (bus.swap_req) state_nx = SWAP_PENDING;
      // A request arriving on the apply cycle is absorbed by this swap.
      SWAP_PENDING: if (vblank_start) begin
                      apply    = 1'b1;
                      state_nx = SWAP_IDLE;
                    end
      default:      state_nx = SWAP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SWAP_IDLE;
      disp_bank_q <= 1'b0;
      swap_ack_q  <= 1'b0;
    end else begin
      state      <= state_nx;
      swap_ack_q <= apply;
      if (apply)
        disp_bank_q <= ~disp_bank_q;
    end
  end

  assign bus.swap_pending = (state == SWAP_PENDING);
  assign bus.swap_ack     = swap_ack_q;
  assign bus.disp_bank    = disp_bank_q;

  // ---------------- column RAM ----------------
  logic              wr_ok;
  logic [Y_BITS-1:0] wr_row;
  logic [X_BITS-1:0] rd_addr;
  logic [Y_BITS-1:0] rd_data;

  assign wr_ok   = bus.wr_en && (32'(bus.wr_addr) < 32'(WIDTH));
  assign wr_row  = Y_BITS'(clamp_row(32'(bus.wr_data), HEIGHT));
  assign rd_addr = (count_h < 32'(WIDTH)) ? count_h[X_BITS-1:0] : '0;

  wave_line_ram #(
    .WIDTH  (WIDTH),
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_bank (~disp_bank_q),
    .wr_addr (bus.wr_addr),
    .wr_data (wr_row),
    .rd_bank (disp_bank_q),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // ---------------- pixel pipeline ----------------
  // Stage 1 holds the counters alongside the RAM read; stage 2 (rd_data is
  // the current column's row) decides the color.
  logic [31:0]       x1, y1;
  logic              v1;
  logic [Y_BITS-1:0] cur_last;
  logic [Y_BITS-1:0] prev, lo, hi;
  logic              in_view, hit;
  logic [BPP-1:0]    color_nx;

  always_comb begin
    in_view = v1 && (x1 < 32'(WIDTH)) && (y1 < 32'(HEIGHT));
    // Column 0 has no left neighbour, so it spans only its own sample.
    prev    = (x1 == 32'd0) ? rd_data : cur_last;
    if (prev <= rd_data) begin
      lo = prev;
      hi = rd_data;
    end else begin
      lo = rd_data;
      hi = prev;
    end
    hit = in_view && (y1 >= 32'(lo)) && (y1 <= 32'(hi));
  end

`ifdef VGA_WAVE_PLOT_GRID_EN
  localparam int GRID_BITS = $clog2(GRID_STEP);
  logic grid;
  assign grid = in_view &&
                ((x1[GRID_BITS-1:0] == '0) || (y1[GRID_BITS-1:0] == '0));

  always_comb begin
    color_nx = BG_COLOR;
    if (hit)
      color_nx = FG_COLOR;
    else if (grid)
      color_nx = GRID_COLOR;
  end
`else
  logic unused_grid_cfg;
  assign unused_grid_cfg = ^{GRID_COLOR, GRID_STEP};

  always_comb begin
    color_nx = BG_COLOR;
    if (hit)
      color_nx = FG_COLOR;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      x1        <= '0;
      y1        <= '0;
      v1        <= 1'b0;
      cur_last  <= '0;
      color_out <= BG_COLOR;
    end else begin
      x1        <= count_h;
      y1        <= count_v;
      v1        <= 1'b1;
      // Off-screen cycles keep the last on-screen sample for the next span.
      if (in_view)
        cur_last <= rd_data;
      color_out <= color_nx;
    end
  end

endmodule

// File: tb/tb_vga_wave_plot.sv
// Self-checking bench for vga_wave_plot: directed counter/write/swap
// vectors; expected pixel colors go into a queue, and a monitor pops and
// compares them when the matching output emerges two cycles later.
module tb_vga_wave_plot;

  localparam logic [7:0] FG   = 8'hFF;
  localparam logic [7:0] BG   = 8'h00;
  localparam logic [7:0] GRID = 8'h49;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] count_h, count_v;
  logic [7:0]  color_out;

  vga_wave_plot_if #(.X_BITS(11), .Y_BITS(10)) bus ();

  vga_wave_plot dut (
    .clk       (clk),
    .reset     (reset),
    .count_h   (count_h),
    .count_v   (count_v),
    .bus       (bus),
    .color_out (color_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         h;
    int         v;
    logic [7:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic chk0 = 1'b0, chk1 = 1'b0, chk2 = 1'b0;

  always @(posedge clk) begin
    chk1 <= chk0;
    chk2 <= chk1;
  end

  // Monitor: a flagged pixel's color is on color_out two edges later.
  always @(negedge clk) begin
    if (chk2) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pixel_unexpected: got %0h required no output", color_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (color_out !== e.c) begin
          errors++;
          $display("FAIL pixel(%0d,%0d): got %0h required %0h", e.h, e.v, color_out, e.c);
        end
      end
    end
  end

  function automatic logic [7:0] pxc(input int x, input int y, input bit hit);
    if (x >= 1280 || y >= 720) return BG;
    if (hit) return FG;
`ifdef VGA_WAVE_PLOT_GRID_EN
    if ((x % 64 == 0) || (y % 64 == 0)) return GRID;
`endif
    return BG;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  // Drive one pixel's counters for one cycle; optionally queue its expectation.
  task automatic px(input int h, input int v, input bit check, input logic [7:0] c);
    exp_t e;
    count_h = h;
    count_v = v;
    chk0    = check;
    if (check) begin
      e.h = h; e.v = v; e.c = c;
      exp_q.push_back(e);
    end
    @(negedge clk);
    chk0 = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px(5, 5, 1'b0, BG);
  endtask

  task automatic wr(input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 11'(addr);
    bus.wr_data = 10'(data);
    px(5, 5, 1'b0, BG);
    bus.wr_en   = 1'b0;
  endtask

  task automatic req_pulse();
    bus.swap_req = 1'b1;
    px(5, 5, 1'b0, BG);
    bus.swap_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    count_h = 5; count_v = 5;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.swap_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_color", color_out, BG);
    chk("reset_pending", bus.swap_pending, 0);
    chk("reset_ack", bus.swap_ack, 0);
    chk("reset_bank", bus.disp_bank, 0);
    reset = 1'b0;
    idle(2);

    // Fill the back bank (bank 1)
    wr(0, 100); wr(1, 100); wr(2, 104); wr(3, 98);
    wr(4, 710); wr(5, 900);
    wr(19, 300); wr(20, 300);
    wr(127, 400); wr(128, 400);
    wr(1300, 50);

    // Swap A
    req_pulse();
    chk("A_pending", bus.swap_pending, 1);
    chk("A_bank_before", bus.disp_bank, 0);
    px(3, 700, 1'b0, BG);
    px(0, 719, 1'b0, BG);
    chk("A_no_early_ack", bus.swap_ack, 0);
    px(0, 720, 1'b0, BG);
    chk("A_ack", bus.swap_ack, 1);
    chk("A_bank", bus.disp_bank, 1);
    chk("A_pending_clr", bus.swap_pending, 0);
    px(1, 720, 1'b0, BG);
    chk("A_ack_one_cycle", bus.swap_ack, 0);

    // Columns 0..3 around the trace
    for (int r = 96; r <= 106; r++) begin
      px(0, r, 1'b1, pxc(0, r, r == 100));
      px(1, r, 1'b1, pxc(1, r, r == 100));
      px(2, r, 1'b1, pxc(2, r, r >= 100 && r <= 104));
      px(3, r, 1'b1, pxc(3, r, r >= 98 && r <= 104));
    end
    // Column 0 ignores the previous column
    px(3, 99, 1'b0, BG);
    px(0, 99, 1'b1, pxc(0, 99, 1'b0));
    // Off-screen x and y
    px(0, 100, 1'b0, BG);
    px(1280, 100, 1'b1, BG);
    px(1, 720, 1'b1, BG);
    // Off-screen cycle must not disturb prev
    px(2, 103, 1'b0, BG);
    px(1280, 103, 1'b1, BG);
    px(3, 103, 1'b1, pxc(3, 103, 1'b1));
    // Clamped write: column 5 holds 719
    px(4, 719, 1'b0, BG); px(5, 719, 1'b1, pxc(5, 719, 1'b1));
    px(4, 709, 1'b0, BG); px(5, 709, 1'b1, pxc(5, 709, 1'b0));
    px(4, 715, 1'b0, BG); px(5, 715, 1'b1, pxc(5, 715, 1'b1));
    // Dropped write at 1300: column 20 still 300
    px(19, 300, 1'b0, BG); px(20, 300, 1'b1, pxc(20, 300, 1'b1));
    px(19, 50, 1'b0, BG);  px(20, 50, 1'b1, pxc(20, 50, 1'b0));
    // Grid column 128
    px(127, 10, 1'b0, BG);  px(128, 10, 1'b1, pxc(128, 10, 1'b0));
    px(127, 400, 1'b0, BG); px(128, 400, 1'b1, pxc(128, 400, 1'b1));
    idle(3);

    // Swap B: two requests in a frame, one swap
    req_pulse();
    idle(2);
    req_pulse();
    chk("B_pending", bus.swap_pending, 1);
    px(0, 720, 1'b0, BG);
    chk("B_ack", bus.swap_ack, 1);
    chk("B_bank", bus.disp_bank, 0);
    px(1, 720, 1'b0, BG);
    chk("B_pending_clr", bus.swap_pending, 0);
    idle(3);
    px(0, 720, 1'b0, BG);
    chk("B_no_second_ack", bus.swap_ack, 0);
    chk("B_bank_hold", bus.disp_bank, 0);

    // Swap C: request on the apply cycle while idle
    idle(2);
    bus.swap_req = 1'b1;
    px(0, 720, 1'b0, BG);
    bus.swap_req = 1'b0;
    chk("C_no_ack", bus.swap_ack, 0);
    chk("C_pending", bus.swap_pending, 1);
    chk("C_bank_hold", bus.disp_bank, 0);
    idle(3);
    px(0, 720, 1'b0, BG);
    chk("C_ack", bus.swap_ack, 1);
    chk("C_bank", bus.disp_bank, 1);

    // E: reset while pending, trace pixel on screen
    idle(3);
    req_pulse();
    px(19, 300, 1'b0, BG);
    px(20, 300, 1'b0, BG);
    px(20, 300, 1'b0, BG);
    chk("E_pre_pending", bus.swap_pending, 1);
    chk("E_pre_color", color_out, FG);
    reset = 1'b1;
    px(20, 300, 1'b0, BG);
    chk("E_pending", bus.swap_pending, 0);
    chk("E_bank", bus.disp_bank, 0);
    chk("E_color", color_out, BG);
    chk("E_ack", bus.swap_ack, 0);
    reset = 1'b0;
    px(1280, 301, 1'b1, BG);
    idle(3);
    px(0, 720, 1'b0, BG);
    chk("E_no_ack", bus.swap_ack, 0);
    chk("E_bank_hold", bus.disp_bank, 0);

    // D: request on the apply cycle while pending
    idle(2);
    req_pulse();
    idle(1);
    bus.swap_req = 1'b1;
    px(0, 720, 1'b0, BG);
    bus.swap_req = 1'b0;
    chk("D_ack", bus.swap_ack, 1);
    chk("D_bank", bus.disp_bank, 1);
    chk("D_pending_clr", bus.swap_pending, 0);
    idle(3);
    px(0, 720, 1'b0, BG);
    chk("D_no_second_ack", bus.swap_ack, 0);
    chk("D_bank_hold", bus.disp_bank, 1);

    idle(4);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
